ex_mdu: RTL
===========

// Module: ex_mdu
// PURPOSE
//  Multi-cycle multiply/divide unit beside the execute stage. Owns the HI/LO registers.
//  Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO. Raises ex_stallreq_o to the controller while busy.
//  Presents HI/LO to the execute stage for MFHI/MFLO.
// PARAMETERS
//  WIDTH      32  operand and HI/LO width (even, >=8)
//  MUL_LAT     2  multiply latency in cycles (1..4); registered product pipeline depth
//  DIV_BPC     1  quotient bits per divider iteration (1 or 2; WIDTH % DIV_BPC == 0)
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        async active-low reset
//  ex_flush_i     in   1        controller flush of the EX instruction
//  ex_stall_i     in   1        controller stall of the EX stage (includes this block's own request)
//  ex_mduop_i     in   MDOP_W   one-hot: [0]MULT [1]MULTU [2]DIV [3]DIVU [4]MTHI [5]MTLO [6]MFHI [7]MFLO
//  ex_opr1_i      in   WIDTH    rs value (multiplicand/dividend; MTHI/MTLO source)
//  ex_opr2_i      in   WIDTH    rt value (multiplier/divisor)
//  ex_stallreq_o  out  1        stall request to controller
//  ex_hi_o        out  WIDTH    current HI
//  ex_lo_o        out  WIDTH    current LO
//  ex_mdu_busy_o  out  1        FSM not in IDLE
// BEHAVIOUR
//  Reset: state=IDLE, HI=LO=0, all outputs 0. Reset is honoured mid-operation; the partial result is discarded.
//  Start condition: start = (mduop[3:0]!=0) & state==IDLE & ~ex_flush_i. Operands are latched in the start cycle.
//  FSM: IDLE -> MUL (mult) | DIV (div); MUL/DIV -> DONE when the counter expires; DONE -> IDLE when ~ex_stall_i.
//   DONE holds while ex_stall_i=1, so a stalled instruction that has completed is never restarted.
//  Latency counted from the start cycle:
//   MUL: HI/LO written at the end of cycle MUL_LAT.
//   DIV: 1 setup cycle (abs values) + WIDTH/DIV_BPC iterations + 1 sign-fix cycle, which writes HI/LO.
//  ex_stallreq_o = (start | state==MUL | state==DIV) & ~ex_flush_i. It is combinational and drops in the DONE cycle.
//  Product: {HI,LO} = 2*WIDTH-bit product; signed for MULT, unsigned for MULTU.
//  Division: LO=quotient, HI=remainder.
//   Remainder takes the sign of the dividend; quotient truncates toward zero.
//   Divisor 0: LO = all-ones, HI = dividend; latency is unchanged.
//   DIV of most-negative by -1: LO = most-negative, HI = 0 (no trap).
//  MTHI/MTLO: write in the same cycle when state==IDLE & ~ex_stall_i & ~ex_flush_i. They never overlap a busy op.
//  MFHI/MFLO: no action here; the execute stage selects ex_hi_o/ex_lo_o.
//   A write in the DONE cycle is visible on the outputs the next cycle.
//  Flush:
//   In any state, the next state is IDLE.
//   The pending HI/LO write is cancelled, including a write in the same cycle as the final iteration.
//   stallreq is 0 in the flush cycle.
//  Flush has priority over start and over MTHI/MTLO in the same cycle.
//  Simultaneous flush and DONE: the HI/LO written on the DONE transition stands. The controller never flushes a retired MDU op.
// STRUCTURE
//  Shared package (defines.v): MDOP bit indices, MDOP_W, FSM state encoding (IDLE/MUL/DIV/DONE).
//  Sub-module ex_mdu_div: iterative restoring divider.
//   Inputs: start, signed, dividend, divisor, cancel.
//   Outputs: done pulse, quo, rem.
//   Contains the iteration counter and divide-by-zero handling.
//  The multiplier is inline: a MUL_LAT-deep register pipeline on the product; the shift-out counter is shared with the FSM.
// TESTING
//  MULT 0xFFFFFFFF x 0x00000002 -> stallreq high for exactly MUL_LAT cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//  DIVU 100 / 7 -> stallreq high 33 cycles (DIV_BPC=1); LO=14, HI=2. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5.
//  MTHI 0x1234 then MTLO 0x5678, then a flush on cycle 10 of a DIV -> HI=0x1234, LO=0x5678 unchanged.
//   Also: stallreq is 0 in the flush cycle and the next MULT starts cleanly.
//  ex_stall_i held high 5 cycles after DONE of a MULTU -> single HI/LO write, no restart, IDLE when stall drops.
//  rst_n low mid-DIV (cycle 17) -> outputs 0 asynchronously; after release a fresh DIVU 9/3 gives LO=3, HI=0.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - one-hot MDU opcode bit positions and opcode width
//   - FSM state encoding used by ex_mdu
package ex_mdu_pkg;

    localparam int MDOP_W     = 8;

    localparam int MDOP_MULT  = 0;
    localparam int MDOP_MULTU = 1;
    localparam int MDOP_DIV   = 2;
    localparam int MDOP_DIVU  = 3;
    localparam int MDOP_MTHI  = 4;
    localparam int MDOP_MTLO  = 5;
    localparam int MDOP_MFHI  = 6;
    localparam int MDOP_MFLO  = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/ex_mdu_if.sv
// Execute-stage <-> MDU signal bundle.
//   master : execute stage / controller side (drives op, operands, flush, stall)
//   slave  : ex_mdu side (returns stall request, HI/LO, busy)
interface ex_mdu_if #(
    parameter int WIDTH = 32
);
    import ex_mdu_pkg::*;

    logic                 ex_flush_i;
    logic                 ex_stall_i;
    logic [MDOP_W-1:0]    ex_mduop_i;
    logic [WIDTH-1:0]     ex_opr1_i;
    logic [WIDTH-1:0]     ex_opr2_i;
    logic                 ex_stallreq_o;
    logic [WIDTH-1:0]     ex_hi_o;
    logic [WIDTH-1:0]     ex_lo_o;
    logic                 ex_mdu_busy_o;

    modport master (
        output ex_flush_i, ex_stall_i, ex_mduop_i, ex_opr1_i, ex_opr2_i,
        input  ex_stallreq_o, ex_hi_o, ex_lo_o, ex_mdu_busy_o
    );

    modport slave (
        input  ex_flush_i, ex_stall_i, ex_mduop_i, ex_opr1_i, ex_opr2_i,
        output ex_stallreq_o, ex_hi_o, ex_lo_o, ex_mdu_busy_o
    );

endinterface

// File: rtl/ex_mdu_div.sv
// Iterative restoring divider, DIV_BPC quotient bits per cycle.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       load operands (setup cycle); absolute values are taken here
//   sgn         signed division
//   dividend    dividend operand
//   divisor     divisor operand
//   cancel      abort the running division
//   done        high during the final iteration cycle
//   quo, rem    sign-corrected results, valid from the cycle after done
module ex_mdu_div #(
    parameter int WIDTH   = 32,
    parameter int DIV_BPC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    localparam int ITERS = WIDTH / DIV_BPC;
    localparam int CNT_W = $clog2(ITERS + 1);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             neg_quo_q, neg_rem_q, dz_q;

    logic [WIDTH-1:0] dividend_abs, divisor_abs;
    logic [WIDTH-1:0] r_nxt, q_nxt;
    logic [WIDTH:0]   r_ext, diff;

    assign dividend_abs = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_abs  = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;

    // quo_q doubles as the dividend shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    always_comb begin
        r_nxt = rem_q;
        q_nxt = quo_q;
        r_ext = '0;
        diff  = '0;
        for (int i = 0; i < DIV_BPC; i++) begin
            r_ext = {r_nxt, q_nxt[WIDTH-1]};
            diff  = r_ext - {1'b0, dvs_q};
            q_nxt = {q_nxt[WIDTH-2:0], ~diff[WIDTH]};
            r_nxt = diff[WIDTH] ? r_ext[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (cancel) begin
            busy_q <= 1'b0;
        end else if (start) begin
            busy_q    <= 1'b1;
            cnt_q     <= CNT_W'(ITERS);
            rem_q     <= '0;
            quo_q     <= dividend_abs;
            dvs_q     <= divisor_abs;
            neg_quo_q <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q <= sgn & dividend[WIDTH-1];
            dz_q      <= (divisor == '0);
        end else if (busy_q) begin
            rem_q <= r_nxt;
            quo_q <= q_nxt;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1))
                busy_q <= 1'b0;
        end
    end

    assign done = busy_q && (cnt_q == CNT_W'(1));

    // Divide by zero: the restoring loop already leaves |dividend| in the
    // remainder, so the remainder sign fix restores the dividend itself;
    // only the quotient needs forcing.
    assign quo = dz_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
    assign rem = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_mdu.sv
// Multi-cycle multiply/divide unit beside the execute stage; owns HI/LO.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   mdu         ex_mdu_if.slave: flush/stall/op/operands in,
//               stallreq/HI/LO/busy out
//
// state | meaning
// IDLE  | ready; accepts MULT/MULTU/DIV/DIVU, applies MTHI/MTLO
// MUL   | product travelling through the register pipeline
// DIV   | divider iterating
// DONE  | result retired (DIV writes HI/LO here); held while stalled
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2,
    parameter int DIV_BPC = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    ex_mdu_if.slave  mdu
);

    mdu_state_e state_q, state_d;

    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic               mul_sgn_q;
    logic [2:0]         cnt_q;
    logic               div_fix_q;

    logic               flush, stall;
    logic               is_mul, is_div, start, mul_last;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic               mul_sgn;
    logic [2*WIDTH-1:0] mul_ext_a, mul_ext_b, mul_prod, mul_src;
    logic               div_done;
    logic [WIDTH-1:0]   div_quo, div_rem;
    logic               unused_mf;

    assign flush  = mdu.ex_flush_i;
    assign stall  = mdu.ex_stall_i;
    assign is_mul = mdu.ex_mduop_i[MDOP_MULT] | mdu.ex_mduop_i[MDOP_MULTU];
    assign is_div = mdu.ex_mduop_i[MDOP_DIV]  | mdu.ex_mduop_i[MDOP_DIVU];

    // MFHI/MFLO are served by the execute stage from ex_hi_o/ex_lo_o.
    assign unused_mf = mdu.ex_mduop_i[MDOP_MFHI] ^ mdu.ex_mduop_i[MDOP_MFLO];

    // rst_n gating keeps stallreq low while reset is held.
    assign start = (is_mul | is_div) & (state_q == ST_IDLE) & ~flush & rst_n;

    // Start cycle multiplies the live operands; later cycles use the latched copy.
    assign mul_a     = start ? mdu.ex_opr1_i : opa_q;
    assign mul_b     = start ? mdu.ex_opr2_i : opb_q;
    assign mul_sgn   = start ? mdu.ex_mduop_i[MDOP_MULT] : mul_sgn_q;
    assign mul_ext_a = {{WIDTH{mul_sgn & mul_a[WIDTH-1]}}, mul_a};
    assign mul_ext_b = {{WIDTH{mul_sgn & mul_b[WIDTH-1]}}, mul_b};
    assign mul_prod  = mul_ext_a * mul_ext_b;

    generate
        if (MUL_LAT == 1) begin : g_mul_comb
            assign mul_src = mul_prod;
        end else begin : g_mul_pipe
            logic [2*WIDTH-1:0] pipe_q [MUL_LAT-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < MUL_LAT - 1; i++)
                        pipe_q[i] <= '0;
                end else if (start || state_q == ST_MUL) begin
                    pipe_q[0] <= mul_prod;
                    for (int i = 1; i < MUL_LAT - 1; i++)
                        pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign mul_src = pipe_q[MUL_LAT-2];
        end
    endgenerate

    assign mul_last = ((state_q == ST_MUL) && (cnt_q == 3'd1)) ||
                      (start && is_mul && (MUL_LAT == 1));

    ex_mdu_div #(
        .WIDTH   (WIDTH),
        .DIV_BPC (DIV_BPC)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start & is_div),
        .sgn      (mdu.ex_mduop_i[MDOP_DIV]),
        .dividend (mdu.ex_opr1_i),
        .divisor  (mdu.ex_opr2_i),
        .cancel   (flush),
        .done     (div_done),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_div)
                        state_d = ST_DIV;
                    else if (MUL_LAT == 1)
                        state_d = ST_DONE;
                    else
                        state_d = ST_MUL;
                end
            end
            ST_MUL:  if (cnt_q == 3'd1) state_d = ST_DONE;
            ST_DIV:  if (div_done)      state_d = ST_DONE;
            ST_DONE: if (!stall)        state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q     <= '0;
            opb_q     <= '0;
            mul_sgn_q <= 1'b0;
            cnt_q     <= '0;
            div_fix_q <= 1'b0;
        end else begin
            if (start && is_mul) begin
                opa_q     <= mdu.ex_opr1_i;
                opb_q     <= mdu.ex_opr2_i;
                mul_sgn_q <= mdu.ex_mduop_i[MDOP_MULT];
                cnt_q     <= 3'(MUL_LAT - 1);
            end else if (state_q == ST_MUL) begin
                cnt_q <= cnt_q - 3'd1;
            end
            // Marks the sign-fix (DONE) cycle of a division that was not flushed.
            div_fix_q <= (state_q == ST_DIV) & div_done & ~flush;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (mul_last && !flush) begin
            {hi_q, lo_q} <= mul_src;
        end else if (div_fix_q) begin
            hi_q <= div_rem;
            lo_q <= div_quo;
        end else if (state_q == ST_IDLE && !stall && !flush) begin
            if (mdu.ex_mduop_i[MDOP_MTHI]) hi_q <= mdu.ex_opr1_i;
            if (mdu.ex_mduop_i[MDOP_MTLO]) lo_q <= mdu.ex_opr1_i;
        end
    end

    assign mdu.ex_stallreq_o = (start | (state_q == ST_MUL) | (state_q == ST_DIV)) & ~flush;
    assign mdu.ex_hi_o       = hi_q;
    assign mdu.ex_lo_o       = lo_q;
    assign mdu.ex_mdu_busy_o = (state_q != ST_IDLE);

endmodule
